sccb_arbiter: RTL and testbench

Round-robin arbiter sharing one SCCB transaction engine (SCCBCtrl) between up to NUM_REQ register-access requesters, e.g. the power-up camera setup sequencer and a runtime host/exposure-control port. It latches the winning requester's address/data/direction, drives the engine's start/done handshake, and returns completion, ack error and read data to the winner only. One transaction at a time; no preemption.

---
 rtl/sccb_arbiter.sv | 140 ++++++++++++++
 tb/tb_sccb_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB transaction engine between NUM_REQ requesters.
// Define SCCB_ARB_TIMEOUT_EN to build the per-transaction watchdog (TIMEOUT_CYCLES).
module sccb_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2_400_000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [8*NUM_REQ-1:0]    addr_i,
  input  logic [16*NUM_REQ-1:0]   data_i,
  input  logic [NUM_REQ-1:0]      rw_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      done_o,
  output logic                    ack_error_o,
  output logic [7:0]              rdata_o,
  output logic                    timeout_o,
  output logic                    eng_start_o,
  output logic [7:0]              eng_addr_o,
  output logic [15:0]             eng_data_o,
  output logic                    eng_rw_o,
  input  logic                    eng_done_i,
  input  logic                    eng_ack_error_i,
  input  logic [7:0]              eng_rdata_i
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Out-of-range configurations elaborate this empty marker block.
  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
  end

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StFinish} state_e;

  state_e          state_q;
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] win_q;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;

  // First asserted request scanning upward from ptr_q + 1, wrapping at NUM_REQ.
  always_comb begin
    int unsigned     k;
    logic [IdxW-1:0] idx;
    k          = 0;
    idx        = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      k   = (32'(ptr_q) + i) % NUM_REQ;
      idx = IdxW'(k);
      if (!pick_valid && req_i[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
  end

`ifdef SCCB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            expired;

  assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= IdxW'(NUM_REQ - 1);
      win_q       <= '0;
      gnt_o       <= '0;
      done_o      <= '0;
      ack_error_o <= 1'b0;
      rdata_o     <= '0;
      eng_start_o <= 1'b0;
      eng_addr_o  <= '0;
      eng_data_o  <= '0;
      eng_rw_o    <= 1'b0;
`ifdef SCCB_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_o   <= 1'b0;
`endif
    end else begin
      done_o <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            win_q      <= pick_idx;
            gnt_o      <= NUM_REQ'(1) << pick_idx;
            eng_addr_o <= addr_i[{pick_idx, 3'b000} +: 8];
            eng_data_o <= data_i[{pick_idx, 4'b0000} +: 16];
            eng_rw_o   <= rw_i[pick_idx];
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          eng_start_o <= 1'b1;
          if (!eng_done_i) state_q <= StBusy;
        end
        StBusy: begin
          if (eng_done_i) begin
            eng_start_o <= 1'b0;
            ack_error_o <= eng_ack_error_i;
            rdata_o     <= eng_rdata_i;
            state_q     <= StFinish;
          end
        end
        StFinish: begin
          done_o  <= gnt_o;
          ptr_q   <= win_q;
          gnt_o   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
`ifdef SCCB_ARB_TIMEOUT_EN
      // Watchdog overrides a same-cycle engine completion.
      timeout_o <= 1'b0;
      if (state_q == StIdle && pick_valid) begin
        cnt_q <= '0;
      end else if (state_q == StIssue || state_q == StBusy) begin
        if (expired) begin
          eng_start_o <= 1'b0;
          timeout_o   <= 1'b1;
          ack_error_o <= 1'b1;
          rdata_o     <= '0;
          state_q     <= StFinish;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Self-checking bench for sccb_arbiter: behavioural engine, round-robin reference model.
module tb_sccb_arbiter;
  localparam int NR = 3;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NR-1:0]    req_i;
  logic [8*NR-1:0]  addr_i;
  logic [16*NR-1:0] data_i;
  logic [NR-1:0]    rw_i;
  logic [NR-1:0]    gnt_o;
  logic [NR-1:0]    done_o;
  logic             ack_error_o;
  logic [7:0]       rdata_o;
  logic             timeout_o;
  logic             eng_start_o;
  logic [7:0]       eng_addr_o;
  logic [15:0]      eng_data_o;
  logic             eng_rw_o;
  logic             eng_done;
  logic             eng_ack_err;
  logic [7:0]       eng_rdata;

  int   n_cmp = 0;
  int   n_err = 0;
  int   last_w;
  logic [7:0]  f_addr [NR];
  logic [15:0] f_data [NR];
  logic        f_rw   [NR];
  int   rem [NR];

  int         cfg_lat = 0;
  bit         cfg_err = 1'b0;
  logic [7:0] cfg_rd  = 8'h00;
  bit         cfg_stuck = 1'b0;

  sccb_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .data_i(data_i),
    .rw_i(rw_i), .gnt_o(gnt_o), .done_o(done_o), .ack_error_o(ack_error_o),
    .rdata_o(rdata_o), .timeout_o(timeout_o), .eng_start_o(eng_start_o),
    .eng_addr_o(eng_addr_o), .eng_data_o(eng_data_o), .eng_rw_o(eng_rw_o),
    .eng_done_i(eng_done), .eng_ack_error_i(eng_ack_err), .eng_rdata_i(eng_rdata)
  );

  always #5 clk_i = ~clk_i;

  // Engine: accepts on a rising start, stays busy cfg_lat+1 cycles, then reports done.
  logic start_d;
  int   busy_cnt;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      eng_done <= 1'b1; start_d <= 1'b0; busy_cnt <= 0; eng_ack_err <= 1'b0; eng_rdata <= 8'h00;
    end else begin
      start_d <= eng_start_o;
      if (eng_done) begin
        if (eng_start_o && !start_d) begin
          eng_done <= 1'b0;
          busy_cnt <= cfg_lat;
        end
      end else if (!cfg_stuck) begin
        if (busy_cnt == 0) begin
          eng_done <= 1'b1; eng_ack_err <= cfg_err; eng_rdata <= cfg_rd;
        end else begin
          busy_cnt <= busy_cnt - 1;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_fields(input int j);
    addr_i[j*8 +: 8]   = f_addr[j];
    data_i[j*16 +: 16] = f_data[j];
    rw_i[j]            = f_rw[j];
  endtask

  task automatic rand_fields(input int j);
    f_addr[j] = 8'($urandom);
    f_data[j] = 16'($urandom);
    f_rw[j]   = 1'($urandom);
  endtask

  function automatic int rr_pick(input int lw);
    for (int i = 1; i <= NR; i++) begin
      if (rem[(lw + i) % NR] > 0) return (lw + i) % NR;
    end
    return -1;
  endfunction

  task automatic wait_gnt(output bit got, output int n);
    got = 1'b0;
    n   = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n++;
      if (gnt_o != '0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Each requester j issues rem[j] back-to-back requests, holding req_i until its last grant.
  task automatic run_phase(input int r0, input int r1, input int r2,
                           input int lat, input int err, input int rd);
    int outstanding, w, n;
    bit got, stable, first_start, s1, s2;
    logic [7:0] la; logic [15:0] ld; logic lr; bit exp_err; logic [7:0] exp_rd;
    rem[0] = r0; rem[1] = r1; rem[2] = r2;
    outstanding = r0 + r1 + r2;
    for (int j = 0; j < NR; j++) begin
      drive_fields(j);
      req_i[j] = (rem[j] > 0);
    end
    while (outstanding > 0) begin
      wait_gnt(got, n);
      chk("gnt_seen", 32'(got), 1);
      if (!got) return;
      chk("gnt_lat", n, 1);
      w = rr_pick(last_w);
      chk("gnt", 32'(gnt_o), 32'(1) << w);
      la = f_addr[w]; ld = f_data[w]; lr = f_rw[w];
      chk("eng_addr", 32'(eng_addr_o), 32'(la));
      chk("eng_data", 32'(eng_data_o), 32'(ld));
      chk("eng_rw", 32'(eng_rw_o), 32'(lr));
      chk("start_at_gnt", 32'(eng_start_o), 0);
      rem[w]--;
      if (rem[w] == 0) req_i[w] = 1'b0;
      rand_fields(w);
      drive_fields(w);
      cfg_lat = (lat < 0) ? $urandom_range(0, 8) : lat;
      cfg_err = (err < 0) ? 1'($urandom) : 1'(err);
      cfg_rd  = (rd < 0) ? 8'($urandom) : 8'(rd);
      exp_err = cfg_err; exp_rd = cfg_rd;
      stable = 1'b1; got = 1'b0; first_start = 1'b0;
      s2 = 1'b0; s1 = eng_start_o;
      for (int c = 0; c < 300; c++) begin
        tick();
        if (c == 0) first_start = eng_start_o;
        if (done_o != '0) begin
          got = 1'b1;
          break;
        end
        if (gnt_o !== NR'(1 << w) || eng_addr_o !== la || eng_data_o !== ld ||
            eng_rw_o !== lr || timeout_o !== 1'b0) stable = 1'b0;
        s2 = s1; s1 = eng_start_o;
      end
      chk("done_seen", 32'(got), 1);
      chk("start_lat", 32'(first_start), 1);
      chk("busy_stable", 32'(stable), 1);
      chk("start_drop", {30'd0, s2, s1}, 32'b10);
      chk("done", 32'(done_o), 32'(1) << w);
      chk("gnt_clr", 32'(gnt_o), 0);
      chk("ack_error", 32'(ack_error_o), 32'(exp_err));
      chk("timeout_idle", 32'(timeout_o), 0);
      if (lr) chk("rdata", 32'(rdata_o), 32'(exp_rd));
      last_w = w;
      outstanding--;
    end
  endtask

  initial begin
    int n;
    bit got, no_done;
    rst_i = 1'b1; req_i = '0; addr_i = '0; data_i = '0; rw_i = '0;
    for (int j = 0; j < NR; j++) rand_fields(j);
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_start", 32'(eng_start_o), 0);
    chk("rst_fields", {eng_rw_o, eng_data_o, eng_addr_o}, 0);
    chk("rst_resp", {ack_error_o, rdata_o, timeout_o}, 0);
    rst_i = 1'b0;
    last_w = NR - 1;
    tick();

    // Single write, 50-cycle engine, no error.
    f_data[0] = 16'h1280; f_rw[0] = 1'b0;
    run_phase(1, 0, 0, 50, 0, -1);
    // Read from requester 1 returning 8'h76.
    f_rw[1] = 1'b1;
    run_phase(0, 1, 0, 10, 0, 8'h76);
    // NACK from the engine.
    run_phase(1, 0, 0, 5, 1, -1);
    // Two requesters held for four transactions: grants alternate.
    run_phase(2, 2, 0, -1, 0, -1);
    // Random contention across all requesters.
    for (int r = 0; r < 6; r++) begin
      run_phase($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), -1, -1, -1);
    end

    // Reset while BUSY: leave pointer at 0, then abort a requester-1 transaction.
    run_phase(1, 0, 0, 3, 0, -1);
    cfg_lat = 40;
    drive_fields(1);
    req_i[1] = 1'b1;
    wait_gnt(got, n);
    chk("rst_busy_gnt", 32'(gnt_o), 32'b010);
    req_i[1] = 1'b0;
    repeat (10) tick();
    chk("rst_busy_start", 32'(eng_start_o), 1);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_gnt", 32'(gnt_o), 0);
    chk("rst_mid_start", 32'(eng_start_o), 0);
    chk("rst_mid_done", 32'(done_o), 0);
    chk("rst_mid_fields", {eng_rw_o, eng_data_o, eng_addr_o}, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    no_done = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done_o != '0) no_done = 1'b0;
    end
    chk("rst_no_done", 32'(no_done), 1);
    last_w = NR - 1;
    run_phase(1, 1, 0, -1, 0, -1);

`ifdef SCCB_ARB_TIMEOUT_EN
    // Engine never completes: watchdog aborts after 100 cycles.
    cfg_stuck = 1'b1;
    rem[0] = 0; rem[1] = 0; rem[2] = 1;
    drive_fields(2);
    req_i[2] = 1'b1;
    wait_gnt(got, n);
    chk("to_gnt", 32'(gnt_o), 32'(1) << rr_pick(last_w));
    req_i[2] = 1'b0;
    n = 0; got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      n++;
      if (timeout_o) begin
        got = 1'b1;
        break;
      end
    end
    chk("to_seen", 32'(got), 1);
    chk("to_cycles", n, 100);
    chk("to_start", 32'(eng_start_o), 0);
    chk("to_done_early", 32'(done_o), 0);
    tick();
    chk("to_done", 32'(done_o), 32'b100);
    chk("to_ack", 32'(ack_error_o), 1);
    chk("to_rdata", 32'(rdata_o), 0);
    chk("to_pulse", 32'(timeout_o), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
